// File: rtl/cache_parameters.sv
// cache_parameters: shared cache geometry, memory bus types and write-back buffer types
package cache_parameters;
  localparam int ADDR_WIDTH = 32;
  localparam int WORD_WIDTH = 32;
  localparam int BLOCK_SIZE = 4;
  localparam int LINE_LSB = 4;
  localparam int TAG_MSB = ADDR_WIDTH - 1;
  localparam int WB_DEPTH = 4;
  localparam int WB_DRAIN_THRESHOLD = 2;
  typedef logic [BLOCK_SIZE-1:0][WORD_WIDTH-1:0] block_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    block_t                data;
    logic                  valid;
  } wb_entry_t;
  typedef enum logic {wb_idle, wb_drain} wb_state_t;
  typedef struct packed {
    logic                  cs;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    block_t                data;
  } memory_request_t;
  typedef struct packed {
    logic ack;
  } memory_response_t;
  function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [ADDR_WIDTH-1:0] a);
    return {a[TAG_MSB:LINE_LSB], {LINE_LSB{1'b0}}};
  endfunction
endpackage

// File: rtl/wb_addr_match.sv
// wb_addr_match: youngest-entry search for lookups and for merge candidates
module wb_addr_match
  import cache_parameters::*;
#(
  parameter  int DEPTH = WB_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t             entries [DEPTH],
  input  logic [PW-1:0]         head,
  input  logic                  skip_head,
  input  logic [ADDR_WIDTH-1:0] lkp_addr,
  input  logic [ADDR_WIDTH-1:0] enq_addr,
  output logic                  lkp_hit,
  output logic [PW-1:0]         lkp_idx,
  output logic                  enq_hit,
  output logic [PW-1:0]         enq_idx
);
  int s;
  // walking oldest to youngest lets the last match win
  always_comb begin
    lkp_hit = 1'b0;
    lkp_idx = '0;
    enq_hit = 1'b0;
    enq_idx = '0;
    s = 0;
    for (int k = 0; k < DEPTH; k++) begin
      s = (int'(head) + k) % DEPTH;
      if (entries[s].valid && entries[s].addr == lkp_addr) begin
        lkp_hit = 1'b1;
        lkp_idx = PW'(s);
      end
      if (entries[s].valid && entries[s].addr == enq_addr && !(skip_head && k == 0)) begin
        enq_hit = 1'b1;
        enq_idx = PW'(s);
      end
    end
  end
endmodule

// File: rtl/cache_wb_buffer.sv
// cache_wb_buffer: merging victim write-back FIFO with youngest-match lookup and drain FSM
module cache_wb_buffer
  import cache_parameters::*;
#(
  parameter  int DEPTH           = WB_DEPTH,
  parameter  int DRAIN_THRESHOLD = WB_DRAIN_THRESHOLD,
  localparam int PW              = $clog2(DEPTH),
  localparam int CW              = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [ADDR_WIDTH-1:0] enq_addr,
  input  block_t                enq_data,
  input  logic [ADDR_WIDTH-1:0] lkp_addr,
  output logic                  lkp_hit,
  output block_t                lkp_data,
  input  logic                  flush,
  output logic                  flush_done,
  output memory_request_t       mem_req,
  input  memory_response_t      mem_resp,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);
  wb_entry_t entries [DEPTH];
  logic [PW-1:0] head, tail, lkp_idx, enq_idx;
  logic enq_hit, flush_pending, push, merge, pop;
  wb_state_t state, state_nx;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  wb_addr_match #(.DEPTH(DEPTH)) u_match (
    .entries  (entries),
    .head     (head),
    .skip_head(state == wb_drain),
    .lkp_addr (line_addr(lkp_addr)),
    .enq_addr (line_addr(enq_addr)),
    .lkp_hit  (lkp_hit),
    .lkp_idx  (lkp_idx),
    .enq_hit  (enq_hit),
    .enq_idx  (enq_idx)
  );
  assign empty      = count == '0;
  assign full       = count == CW'(DEPTH);
  assign enq_ready  = !full;
  assign merge      = enq_valid && enq_ready && enq_hit;
  assign push       = enq_valid && enq_ready && !enq_hit;
  assign pop        = state == wb_drain && mem_resp.ack;
  assign flush_done = flush_pending && empty && state == wb_idle;
  assign lkp_data   = lkp_hit ? entries[lkp_idx].data : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (merge) entries[enq_idx].data <= enq_data;
      if (push) begin
        entries[tail] <= '{addr: line_addr(enq_addr), data: enq_data, valid: 1'b1};
        tail          <= nxt(tail);
      end
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= nxt(head);
      end
      count         <= count + CW'(push) - CW'(pop);
      flush_pending <= flush_done ? 1'b0 : (flush_pending | flush);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= wb_idle;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx = state == wb_idle
      ? ((count >= CW'(DRAIN_THRESHOLD) || (flush_pending && !empty)) ? wb_drain : wb_idle)
      : (mem_resp.ack ? wb_idle : wb_drain);
  end
  always_comb begin
    mem_req = '0;
    if (state == wb_drain) mem_req = '{cs: 1'b1, rw: 1'b1, addr: entries[head].addr, data: entries[head].data};
  end
endmodule

// File: tb/tb_cache_wb_buffer.sv
// tb_cache_wb_buffer: directed and random stimulus against a queue-based write-back model
module tb_cache_wb_buffer;
  import cache_parameters::*;
  logic clk = 1'b0;
  logic rst_n;
  logic enq_valid, enq_ready, lkp_hit, flush, flush_done, empty, full;
  logic [31:0] enq_addr, lkp_addr;
  block_t enq_data, lkp_data;
  memory_request_t mem_req;
  memory_response_t mem_resp;
  logic [2:0] count;
  typedef struct {
    logic [31:0] a;
    block_t      d;
  } ment_t;
  ment_t mq[$];
  bit busy, pend;
  int n_chk, n_fail;
  block_t blk_a, blk_b;
  int dones;

  cache_wb_buffer dut (
    .clk(clk), .rst_n(rst_n), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_addr(enq_addr), .enq_data(enq_data), .lkp_addr(lkp_addr), .lkp_hit(lkp_hit),
    .lkp_data(lkp_data), .flush(flush), .flush_done(flush_done), .mem_req(mem_req),
    .mem_resp(mem_resp), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
    return a[31:4] == b[31:4];
  endfunction

  function automatic block_t rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_outputs();
    bit hit;
    block_t ld;
    hit = 0;
    ld = '0;
    foreach (mq[i]) if (same_line(mq[i].a, lkp_addr)) begin
      hit = 1;
      ld = mq[i].d;
    end
    check("count", count, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == 4);
    check("enq_ready", enq_ready, mq.size() != 4);
    check("lkp_hit", lkp_hit, hit);
    check("lkp_data", lkp_data, ld);
    check("cs", mem_req.cs, busy);
    check("rw", mem_req.rw, busy);
    check("mem_addr", mem_req.addr, busy ? {mq[0].a[31:4], 4'h0} : 32'h0);
    check("mem_data", mem_req.data, busy ? mq[0].d : '0);
    check("flush_done", flush_done, pend && mq.size() == 0 && !busy);
  endtask

  task automatic model_update();
    int sz, hit;
    bit acc, ack_e, done_m, nbusy;
    ment_t e;
    sz = mq.size();
    acc = enq_valid && sz != 4;
    ack_e = busy && mem_resp.ack;
    done_m = pend && sz == 0 && !busy;
    nbusy = busy ? !ack_e : (sz >= 2 || (pend && sz > 0));
    if (acc) begin
      hit = -1;
      for (int i = busy ? 1 : 0; i < sz; i++) if (same_line(mq[i].a, enq_addr)) hit = i;
      if (hit >= 0) mq[hit].d = enq_data;
      else begin
        e.a = enq_addr;
        e.d = enq_data;
        mq.push_back(e);
      end
    end
    if (ack_e) void'(mq.pop_front());
    busy = nbusy;
    pend = done_m ? 1'b0 : (pend | flush);
  endtask

  task automatic cyc(input logic ev, input logic [31:0] ea, input block_t ed,
                     input logic fl, input logic ak, input logic [31:0] la);
    enq_valid = ev;
    enq_addr = ea;
    enq_data = ed;
    flush = fl;
    mem_resp.ack = ak;
    lkp_addr = la;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input logic ak);
    cyc(1'b0, 32'h0, '0, 1'b0, ak, 32'h0);
  endtask

  task automatic enq(input logic [31:0] a, input block_t d, input logic ak);
    cyc(1'b1, a, d, 1'b0, ak, a);
  endtask

  task automatic drain_all();
    int n;
    cyc(1'b0, 32'h0, '0, 1'b1, 1'b1, 32'h0);
    n = 0;
    while ((mq.size() != 0 || busy || pend) && n < 40) begin
      idle(1'b1);
      n++;
    end
    check("drain_timeout", n < 40, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    enq_valid = 0; enq_addr = 0; enq_data = '0; flush = 0; mem_resp = '0; lkp_addr = 0;
    #3;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", enq_ready, 1);
    check("rst_hit", lkp_hit, 0);
    check("rst_ldata", lkp_data, 0);
    check("rst_done", flush_done, 0);
    check("rst_req", mem_req, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    blk_a = rnd_blk();
    blk_b = rnd_blk();
    enq(32'h100, blk_a, 0);
    enq(32'h200, blk_b, 0);
    idle(0);
    check("r035_cs", mem_req.cs, 1);
    check("r035_addr", mem_req.addr, 32'h100);
    check("r035_data", mem_req.data, blk_a);
    idle(0); idle(0); idle(1);
    check("r035_count", count, 1);
    check("r035_gap", mem_req.cs, 0);
    drain_all();

    enq(32'h300, blk_a, 0);
    enq(32'h300, blk_b, 0);
    check("r036_count", count, 1);
    lkp_addr = 32'h304;
    #1;
    check("r036_hit", lkp_hit, 1);
    check("r036_data", lkp_data, blk_b);
    drain_all();

    for (int i = 0; i < 4; i++) enq(32'h500 + 32'h100 * i, rnd_blk(), 0);
    check("r037_full", full, 1);
    check("r037_ready", enq_ready, 0);
    enq(32'h900, blk_a, 0);
    enq(32'h900, blk_a, 1);
    enq(32'h900, blk_a, 0);
    check("r037_count", count, 4);
    drain_all();

    enq(32'h400, blk_a, 0);
    enq(32'ha00, rnd_blk(), 0);
    idle(0);
    enq(32'h400, blk_b, 0);
    check("r038_count", count, 3);
    lkp_addr = 32'h400;
    #1;
    check("r038_data", lkp_data, blk_b);
    for (int i = 0; i < 12; i++) idle(i % 2 == 1);
    drain_all();

    enq(32'hb00, blk_a, 0);
    cyc(1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      idle(i >= 3);
      dones += int'(flush_done);
    end
    check("r039_single_done", dones, 1);
    check("r039_empty", empty, 1);
    cyc(1'b0, 32'h0, '0, 1'b1, 1'b0, 32'h0);
    check("r039_done_next", flush_done, 1);
    idle(0);
    check("r039_done_pulse", flush_done, 0);

    enq(32'hc00, rnd_blk(), 0);
    enq(32'hd00, rnd_blk(), 0);
    idle(0);
    check("r040_cs_before", mem_req.cs, 1);
    #2 rst_n = 1'b0;
    #1;
    check("r040_cs_async", mem_req.cs, 0);
    check("r040_count_async", count, 0);
    mq.delete();
    busy = 0;
    pend = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("r040_empty", empty, 1);
    idle(0);

    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 1), ($urandom_range(1, 6) << 8) | $urandom_range(0, 15), rnd_blk(),
          $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
          ($urandom_range(1, 6) << 8) | $urandom_range(0, 15));
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_wb_buffer.md
CACHE_WB_BUFFER -- requirements
Module: cache_wb_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of victim-block entries (any integer >= 2).
REQ-002 The block SHALL have parameter DRAIN_THRESHOLD, default 2, meaning the occupancy at which draining starts without a flush (range 1..DEPTH).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk input 1 (rising edge), rst_n input 1 (asynchronous, active-low).
REQ-004 The block SHALL have enq_valid input 1, meaning a dirty victim block is offered.
REQ-005 The block SHALL have enq_ready output 1, meaning the offer is accepted this cycle.
REQ-006 The block SHALL have enq_addr input ADDR_WIDTH, meaning the victim block address (offset bits ignored).
REQ-007 The block SHALL have enq_data input WORD_WIDTH x BLOCK_SIZE, meaning the victim block data.
REQ-008 The block SHALL have lkp_addr input ADDR_WIDTH, meaning the refill address to search.
REQ-009 The block SHALL have lkp_hit output 1, meaning the block is present in the buffer.
REQ-010 The block SHALL have lkp_data output WORD_WIDTH x BLOCK_SIZE, meaning the newest matching block data.
REQ-011 The block SHALL have flush input 1 (single-cycle pulse) and flush_done output 1 (single-cycle pulse).
REQ-012 The block SHALL have mem_req output memory_request_t and mem_resp input memory_response_t.
REQ-013 The block SHALL have count output clog2(DEPTH+1), empty output 1 and full output 1, meaning occupancy status.

Function
REQ-014 The buffer SHALL be a circular FIFO of DEPTH entries with head/tail pointers wrapping from DEPTH-1 to 0.
REQ-015 enq_ready SHALL equal !full, computed from registered state only; a pop in the same cycle does not make a full buffer accept.
REQ-016 Address matching SHALL compare bits TAG_MSB..LINE_LSB only.
REQ-017 An accepted enqueue whose address matches a valid entry that is not in flight SHALL overwrite that entry's data in place, leaving count unchanged (merge).
REQ-018 Any other accepted enqueue SHALL write at tail and increment count; an entry is visible to lookup in the cycle after acceptance.
REQ-019 Lookup SHALL be combinational over all valid entries, including the in-flight one; when several entries match, the youngest SHALL win; with no match, lkp_hit=0 and lkp_data=0.
REQ-020 The drain FSM SHALL have states wb_idle and wb_drain.
REQ-021 wb_idle -> wb_drain SHALL occur when count>=DRAIN_THRESHOLD, or when a flush is pending and count>0.
REQ-022 In wb_drain, mem_req SHALL present cs=1, rw=1, addr=head address with offset bits zero and data=head data, all held stable until mem_resp.ack=1.
REQ-023 On ack, the head SHALL be popped and the FSM SHALL return to wb_idle, leaving at least one cs=0 cycle between requests.
REQ-024 In wb_idle, mem_req.cs SHALL be 0.
REQ-025 A flush pulse SHALL set flush_pending; when count reaches 0 and the FSM is in wb_idle, flush_done SHALL pulse for one cycle and flush_pending SHALL clear.
REQ-026 A flush on an already empty buffer SHALL produce flush_done on the next cycle.
REQ-027 A flush arriving while one is pending SHALL be absorbed, producing a single flush_done.
REQ-028 Enqueue and ack in the same cycle SHALL produce a net count change of 0.
REQ-029 empty SHALL equal (count==0); full SHALL equal (count==DEPTH).

Reset
REQ-030 While rst_n=0, all entry valid bits, pointers, count and flush_pending SHALL be cleared, and the FSM SHALL be in wb_idle, independent of clk.
REQ-031 Reset values: enq_ready=1, empty=1, full=0, count=0, lkp_hit=0, lkp_data=0, flush_done=0, mem_req.cs=0, mem_req.rw=0, mem_req.addr=0, mem_req.data=0.
REQ-032 An assertion of rst_n=0 mid-drain SHALL drop mem_req.cs to 0 asynchronously, and the entry SHALL be discarded.

Structure
REQ-033 WB_DEPTH, WB_DRAIN_THRESHOLD, wb_entry_t {addr, data[BLOCK_SIZE], valid} and wb_state_t {wb_idle, wb_drain} SHALL live in cache_parameters.
REQ-034 The youngest-match search SHALL be one combinational sub-module, wb_addr_match, instantiated once.

Verification (DEPTH=4, DRAIN_THRESHOLD=2)
REQ-035 Enqueue 0x100 then 0x200 -> count 2, then mem_req cs=1 with addr 0x100; ack after 3 cycles -> count 1 and cs=0 for at least one cycle.
REQ-036 Enqueue 0x300 with data A, then 0x300 with data B while not in flight -> count 1, lkp_addr=0x304 returns lkp_hit=1 with data B.
REQ-037 Enqueue 5 blocks with ack withheld -> 5th offer sees enq_ready=0 and full=1; the 5th is accepted only after an ack.
REQ-038 Enqueue 0x400 while it is in flight, then lookup 0x400 -> two entries exist and the new data is returned; both are written to memory in order.
REQ-039 One entry plus flush -> drains without reaching threshold, then a single flush_done pulse; a flush when empty -> flush_done the next cycle.
REQ-040 rst_n=0 asserted during a drain with cs=1 -> cs=0 immediately, and count=0, empty=1 after release.
